// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NUM_IN-input round-robin arbitrated multiplexer with valid/ready handshakes and a registered output.
// Define RR_ARB_MUX_LOCK_EN to add in_last and hold the grant on one channel for a whole multi-word packet.
module rr_arb_mux #(
   parameter  int WIDTH  = 64,
   parameter  int NUM_IN = 4,
   localparam int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
`ifdef RR_ARB_MUX_LOCK_EN
   input  logic [NUM_IN-1:0]       in_last,
`endif
   output logic [NUM_IN-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_sel
);

   if (WIDTH < 1) begin : g_bad_width
      $error("rr_arb_mux: WIDTH must be >= 1");
   end
   if (NUM_IN < 2) begin : g_bad_num_in
      $error("rr_arb_mux: NUM_IN must be >= 2");
   end

   logic [WIDTH-1:0] chan [NUM_IN];
   logic [WIDTH-1:0] data_p1;
   logic [SEL_W-1:0] sel_p1;
   logic             vld_p1;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] rr_grant;
   logic             rr_any;
   logic [SEL_W-1:0] grant;
   logic             any_valid;
   logic             load_en;
   logic             xfer;
   logic [SEL_W-1:0] ptr_next;

   for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
      assign chan[i]     = in_data[i*WIDTH +: WIDTH];
      assign in_ready[i] = xfer & (grant == SEL_W'(i));
   end

   // Walk from the highest offset down so the channel closest to ptr wins.
   always_comb begin : rr_scan
      logic [SEL_W:0]   sum;
      logic [SEL_W-1:0] idx;
      rr_any   = 1'b0;
      rr_grant = '0;
      sum      = '0;
      idx      = '0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (SEL_W+1)'(k);
         if (sum >= (SEL_W+1)'(NUM_IN)) begin
            sum = sum - (SEL_W+1)'(NUM_IN);
         end
         idx = sum[SEL_W-1:0];
         if (in_valid[idx]) begin
            rr_any   = 1'b1;
            rr_grant = idx;
         end
      end
   end

`ifdef RR_ARB_MUX_LOCK_EN
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t           state;
   logic [SEL_W-1:0] lock_sel;

   // While locked only the owning channel may transfer, even if it is momentarily idle.
   always_comb begin
      if (state == LOCKED) begin
         grant     = lock_sel;
         any_valid = in_valid[lock_sel];
      end else begin
         grant     = rr_grant;
         any_valid = rr_any;
      end
   end
`else
   assign grant     = rr_grant;
   assign any_valid = rr_any;
`endif

   assign load_en  = !vld_p1 | out_ready;
   assign xfer     = load_en & any_valid & !reset;
   assign ptr_next = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + SEL_W'(1);

   // Output register stage: load on transfer, otherwise drain when the consumer accepts.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1   <= 1'b0;
         data_p1  <= '0;
         sel_p1   <= '0;
         ptr      <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
         state    <= IDLE;
         lock_sel <= '0;
`endif
      end else if (xfer) begin
         data_p1 <= chan[grant];
         sel_p1  <= grant;
         vld_p1  <= 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
         case (state)
            IDLE: begin
               if (in_last[grant]) begin
                  ptr <= ptr_next;
               end else begin
                  state    <= LOCKED;
                  lock_sel <= grant;
               end
            end
            LOCKED: begin
               if (in_last[grant]) begin
                  ptr   <= ptr_next;
                  state <= IDLE;
               end
            end
         endcase
`else
         ptr <= ptr_next;
`endif
      end else if (out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_data  = data_p1;
   assign out_sel   = sel_p1;
   assign out_valid = vld_p1;

   a_grant_onehot : assert property (@(posedge clk) $onehot0(in_ready));

   a_stall_hold : assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus randomized traffic against a behavioural model.
module tb_rr_arb_mux;
   localparam int N = 4;
   localparam int W = 64;

   logic           clk = 1'b0;
   logic           reset;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic [1:0]     out_sel;
`ifdef RR_ARB_MUX_LOCK_EN
   logic [N-1:0]   in_last;
`endif
   logic [W-1:0]   cd [N];

   always #5 clk = ~clk;
   assign in_data = {cd[3], cd[2], cd[1], cd[0]};

   rr_arb_mux #(.WIDTH(W), .NUM_IN(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
`ifdef RR_ARB_MUX_LOCK_EN
      .in_last   (in_last),
`endif
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: the output word, its source and the arbitration pointer.
   bit           m_vld  = 1'b0;
   logic [W-1:0] m_data = '0;
   int           m_sel  = 0;
   int           m_ptr  = 0;
   bit           m_lock = 1'b0;
   int           m_lsel = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[2'((p + k) % N)]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int model_grant();
      if (reset || !(!m_vld || out_ready)) return -1;
      if (m_lock) return in_valid[2'(m_lsel)] ? m_lsel : -1;
      return pick(in_valid, m_ptr);
   endfunction

   function automatic logic [N-1:0] model_ready();
      int g = model_grant();
      if (g < 0) return '0;
      return N'(1) << g;
   endfunction

   // Entered just after a negedge with inputs applied; returns at the next negedge.
   task automatic cycle();
      int g;
      #1;
      check_eq("in_ready", 64'(in_ready), 64'(model_ready()));
      g = model_grant();
      @(posedge clk);
      if (reset) begin
         m_vld = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0; m_lock = 1'b0;
      end else if (g >= 0) begin
         m_vld  = 1'b1;
         m_data = cd[g];
         m_sel  = g;
`ifdef RR_ARB_MUX_LOCK_EN
         if (in_last[2'(g)]) begin
            m_lock = 1'b0;
            m_ptr  = (g + 1) % N;
         end else begin
            m_lock = 1'b1;
            m_lsel = g;
         end
`else
         m_ptr = (g + 1) % N;
`endif
      end else if (out_ready) begin
         m_vld = 1'b0;
      end
      #1;
      check_eq("out_valid", 64'(out_valid), 64'(m_vld));
      check_eq("out_data", out_data, m_data);
      check_eq("out_sel", 64'(out_sel), 64'(m_sel));
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      logic [N-1:0] sparse_exp [3];
      sparse_exp[0] = 4'b1000;
      sparse_exp[1] = 4'b0010;
      sparse_exp[2] = 4'b1000;
      for (int i = 0; i < N; i++) cd[i] = '0;
      reset     = 1'b1;
      in_valid  = '1;
      out_ready = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
      in_last   = '1;
`endif

      // Reset held two cycles with every channel requesting.
      for (int i = 0; i < N; i++) cd[i] = W'(32'hA0 + i);
      cycle();
      cycle();
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_data", out_data, 64'd0);
      check_eq("rst_out_sel", 64'(out_sel), 64'd0);
      reset = 1'b0;
      #1;
      check_eq("first_grant", 64'(in_ready), 64'b0001);

      // Round robin with a continuously ready consumer.
      for (int j = 0; j < 5; j++) begin
         cycle();
         check_eq("rr_sel", 64'(out_sel), 64'(j % N));
         check_eq("rr_data", out_data, 64'(32'hA0 + j % N));
         check_eq("rr_valid", 64'(out_valid), 64'd1);
      end

      // Backpressure after a load from channel 2.
      do_reset();
      in_valid = 4'b0100;
      cd[2]    = 64'h1234;
      cycle();
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         #1;
         check_eq("bp_in_ready", 64'(in_ready), 64'd0);
         cycle();
         check_eq("bp_data", out_data, 64'h1234);
         check_eq("bp_sel", 64'(out_sel), 64'd2);
      end
      out_ready = 1'b1;
      #1;
      check_eq("bp_next_grant", 64'(in_ready), 64'b1000);
      cycle();
      check_eq("bp_next_sel", 64'(out_sel), 64'd3);

      // Sparse requests on channels 3 and 1 starting from ptr=2.
      do_reset();
      in_valid = 4'b0010;
      cycle();
      in_valid = 4'b1010;
      for (int j = 0; j < 3; j++) begin
         #1;
         check_eq("sparse_grant", 64'(in_ready), 64'(sparse_exp[j]));
         cycle();
      end

      // Single word drained with nothing behind it.
      do_reset();
      in_valid = 4'b0010;
      cd[1]    = 64'h55;
      cycle();
      check_eq("drain_v1", 64'(out_valid), 64'd1);
      in_valid = '0;
      cycle();
      check_eq("drain_v0", 64'(out_valid), 64'd0);
      check_eq("drain_hold", out_data, 64'h55);
      cycle();
      check_eq("drain_v0b", 64'(out_valid), 64'd0);

`ifdef RR_ARB_MUX_LOCK_EN
      // Three-word packet on channel 0 while channel 1 keeps requesting.
      do_reset();
      in_valid = 4'b0011;
      for (int j = 0; j < 4; j++) begin
         in_last = (j == 2) ? 4'b0011 : 4'b0010;
         cd[0]   = W'(32'h100 + j);
         cycle();
         check_eq("lock_sel", 64'(out_sel), (j < 3) ? 64'd0 : 64'd1);
      end
      // Lock on channel 2, idle owner blocks others, then reset mid-packet.
      do_reset();
      in_valid = 4'b0010; in_last = 4'b0010;
      cycle();
      in_valid = 4'b0100; in_last = 4'b0000;
      cycle();
      in_valid = 4'b1011;
      #1;
      check_eq("lock_block", 64'(in_ready), 64'd0);
      cycle();
      do_reset();
      in_valid = 4'b1111; in_last = 4'b1111;
      #1;
      check_eq("lock_rst_grant", 64'(in_ready), 64'b0001);
      cycle();
`endif

      // Randomized traffic with occasional resets.
      for (int j = 0; j < 3000; j++) begin
         reset     = ($urandom_range(0, 63) == 0);
         in_valid  = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_ARB_MUX_LOCK_EN
         in_last   = N'($urandom);
`endif
         for (int i = 0; i < N; i++) cd[i] = {$urandom, $urandom};
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised successor to the 2:1 bit mux: an N-input, W-bit multiplexer with round-robin arbitration, per-input valid/ready handshakes and a registered output stage.
- Merges multiple producers onto one datapath consumer, e.g. writeback/result sources or memory request sources in the CPU.
- Selection comes from the internal fair arbiter, not from an external select line.

Parameters:
- WIDTH, 64, data bits per channel; must be >= 1.
- NUM_IN, 4, number of input channels; must be >= 2.
- SEL_W, $clog2(NUM_IN), width of the source index (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  channel i presents data.
- in_ready  output  NUM_IN  channel i transfers this cycle; combinational.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data.
- out_sel  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (reset=1 at a clk edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Priority pointer ptr=0.
  - in_ready is all zero while reset is high.
  - Reset asserted mid-transfer discards the held word; no transfer completes on that edge.
- Storage: a single output register.
  - load_en = !out_valid | out_ready.
  - Full throughput of one word per cycle when out_ready is held high.
- Arbitration (combinational):
  - Scan channels ptr, ptr+1, ..., ptr+NUM_IN-1, with indices taken mod NUM_IN.
  - The first channel with in_valid=1 is the grant g.
  - in_ready[i] = load_en & any_valid & (i==g). At most one bit is set (one-hot or zero).
  - in_ready must not depend on out_data or on the other in_ready bits.
- Transfer on a clk edge where in_valid[g] & in_ready[g]:
  - out_data <= channel g data; out_sel <= g; out_valid <= 1.
  - ptr <= (g+1) mod NUM_IN, wrapping from NUM_IN-1 to 0.
- Drain with no load: out_valid & out_ready & no input transfer gives out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and load in the same cycle: the new word replaces the old one and out_valid stays 1.
- Stall (out_valid & !out_ready):
  - out_data, out_sel and out_valid stay stable.
  - All in_ready bits are 0.
  - ptr does not change.
- No valid inputs: ptr unchanged, no load.
- Latency: 1 cycle from the input transfer edge to out_valid.
- Fairness: any channel holding in_valid continuously is served within NUM_IN transfers.
- Producers must hold in_data stable while in_valid=1 and in_ready=0; the block does not check this.

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN.
- Defined:
  - Adds port in_last, input, NUM_IN bits; in_last[i] marks the final word of a multi-word packet on channel i.
  - Two-state FSM:
    - IDLE: normal round-robin. A transfer from g with in_last[g]=0 moves to LOCKED(g); ptr is not advanced.
    - LOCKED(g): grant is forced to g whenever in_valid[g]=1; other channels get in_ready=0 even when g is idle. A transfer with in_last[g]=1 sets ptr <= g+1 and returns to IDLE.
  - Reset returns the FSM to IDLE.
- Not defined: no in_last port, no FSM; every transfer advances ptr as above.

Test Plan:
- Reset, then check outputs: hold reset=1 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0; after release, first grant goes to channel 0.
- Round robin with continuous consumer: NUM_IN=4, all channels valid with data 0xA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0; out_data 0xA0,0xA1,0xA2,0xA3,0xA0; out_valid=1 every cycle after the first.
- Backpressure: out_ready=0 for 5 cycles after a load of 0x1234 from channel 2 -> out_data=0x1234 and out_sel=2 held stable, in_ready=0000, ptr frozen; next grant is channel 3 once out_ready=1.
- Sparse requests and wrap: only channels 3 and 1 valid, ptr=2 -> grant order 3, 1, 3; ptr wraps from 3 to 0 correctly.
- Drain without reload: a single word on channel 1, then no valids, out_ready=1 -> out_valid high for exactly 1 cycle then 0, out_data holds the last value.
- With RR_ARB_MUX_LOCK_EN: channel 0 sends 3 words (in_last on the third) while channel 1 stays valid -> out_sel = 0,0,0,1; a mid-packet reset yields IDLE with ptr=0.
